fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline.
- Sits directly upstream of the decode stage.
- Consumes the hazard unit's stall output as `freeze` and the branch resolution as `branch_taken`/`branch_addr`.
- Drives a req/ack instruction-memory port with variable latency and presents PC+4, instruction and valid to decode.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.
- PC_INC, 4, PC increment per instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard stall from hazard detection; holds IF/ID and PC.
- branch_taken  in  1  redirect request; flushes IF/ID.
- branch_addr  in  ADDR_W  redirect target.
- imem_req  out  1  memory request valid.
- imem_addr  out  ADDR_W  request address.
- imem_ack  in  1  request complete; imem_rdata valid this cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- pc_IF_ID  out  ADDR_W  fetch address + PC_INC of the held instruction.
- instr_IF_ID  out  INSTR_W  held instruction.
- valid_IF_ID  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_busy  out  1  high in DROP or when a FETCH cycle had no ack (debug/perf).

Behaviour:
- Reset:
  - state=FETCH; fetch_pc=RESET_PC.
  - pc_IF_ID=0, instr_IF_ID=0, valid_IF_ID=0; hold buffer empty.
  - imem_req=0 while rst is high.
- Registers:
  - fetch_pc drives imem_addr.
  - redirect_pc.
  - hold buffer: instr and pc, 1 entry.
- FSM states FETCH, DROP, HOLD. imem_req=1 in FETCH and DROP, 0 in HOLD.
- Memory protocol:
  - Once imem_req is asserted, imem_addr is stable until the cycle imem_ack=1.
  - Ack is allowed in the same cycle as the first req (zero-wait).
- FETCH, priority order:
  - branch_taken & ack: discard rdata; fetch_pc<=branch_addr; valid_IF_ID<=0; stay FETCH.
  - branch_taken & !ack: redirect_pc<=branch_addr; valid_IF_ID<=0; go DROP.
  - ack & !freeze: IF/ID<={fetch_pc+PC_INC, rdata, valid=1}; fetch_pc<=fetch_pc+PC_INC; stay FETCH.
  - ack & freeze: hold buffer<={fetch_pc+PC_INC, rdata}; fetch_pc<=fetch_pc+PC_INC; IF/ID unchanged; go HOLD.
  - !ack & !freeze: valid_IF_ID<=0 (bubble; pc/instr fields may keep old values).
  - !ack & freeze: IF/ID unchanged.
- DROP:
  - Keeps requesting the old address.
  - branch_taken overwrites redirect_pc.
  - On ack: discard rdata; fetch_pc<=redirect_pc; go FETCH.
  - valid_IF_ID stays 0 throughout.
- HOLD:
  - No request.
  - freeze=1: all state held.
  - freeze=0: IF/ID<=hold buffer with valid=1; go FETCH.
  - branch_taken (any freeze): discard hold buffer; valid_IF_ID<=0; fetch_pc<=branch_addr; go FETCH.
- Branch vs freeze: branch_taken overrides freeze in every state. The flush clears valid_IF_ID even when frozen.
- Arithmetic: PC_INC addition is modulo 2^ADDR_W; wrap from all-ones is silent.
- rst has priority over all inputs. Reset mid-transaction abandons the outstanding request. The memory must tolerate a dropped req, i.e. an ack arriving in the reset cycle is ignored.
- No instruction is ever lost or duplicated across freeze, and order is preserved.

Test Plan:
- Reset then zero-wait memory (ack same cycle), no stalls -> imem_addr 0,4,8,12 on consecutive cycles; valid_IF_ID=1 from cycle 2; pc_IF_ID 4,8,12.
- Memory with 2-cycle latency -> imem_addr held stable over both cycles; valid_IF_ID pulses 1 every 3rd cycle; fetch_busy high during wait cycles.
- freeze=1 for 3 cycles with ack arriving during freeze (instr 0xAAAA0000 at addr 0x10) -> IF/ID unchanged while frozen; state HOLD, imem_req=0. On release, IF/ID = {0x14, 0xAAAA0000, 1}; next request at 0x14.
- branch_taken with branch_addr=0x100 during 2-cycle wait at addr 0x20 -> addr 0x20 held until ack; returned data discarded; next imem_addr=0x100; valid_IF_ID=0 until the 0x100 instruction lands.
- branch_taken and freeze both high while in HOLD -> hold buffer discarded; valid_IF_ID=0; next fetch at branch_addr.
- RESET_PC=0xFFFFFFFC, zero-wait memory -> addresses 0xFFFFFFFC then 0x00000000; pc_IF_ID=0x00000000 for the first instruction.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of the MIPS
//   pipeline. It fetches through a req/ack instruction memory with variable
//   latency, absorbs hazard stalls (freeze) with a one-entry hold buffer and
//   handles branch redirects, including redirects that arrive while a request
//   is still outstanding.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   freeze            hazard stall: holds IF/ID and the fetch PC
//   branch_taken      redirect request, flushes IF/ID
//   branch_addr       redirect target
//   imem_req/addr     memory request; addr is stable until imem_ack
//   imem_ack/rdata    request completion and returned instruction
//   pc_IF_ID          fetch address + PC_INC of the held instruction
//   instr_IF_ID       held instruction
//   valid_IF_ID       IF/ID holds a real instruction (0 = bubble)
//   fetch_busy        DROP state, or a FETCH cycle without ack
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_INC   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc_IF_ID,
  output logic [INSTR_W-1:0] instr_IF_ID,
  output logic               valid_IF_ID,
  output logic               fetch_busy
);

  typedef enum logic [1:0] {
    FETCH,
    DROP,
    HOLD
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  fetch_pc_q;
  logic [ADDR_W-1:0]  redirect_pc_q;
  logic [ADDR_W-1:0]  hold_pc_q;
  logic [INSTR_W-1:0] hold_instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;

  // Sequential PC; the addition wraps silently modulo 2^ADDR_W.
  logic [ADDR_W-1:0]  pc_inc_d;
  assign pc_inc_d = fetch_pc_q + ADDR_W'(PC_INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= '0;
      hold_pc_q     <= '0;
      hold_instr_q  <= '0;
      pc_q          <= '0;
      instr_q       <= '0;
      valid_q       <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (branch_taken) begin
            valid_q <= 1'b0;
            if (imem_ack) begin
              // Returned word belongs to the wrong path; drop it.
              fetch_pc_q <= branch_addr;
            end else begin
              // Address must stay stable until ack, so park the target.
              redirect_pc_q <= branch_addr;
              state_q       <= DROP;
            end
          end else if (imem_ack) begin
            fetch_pc_q <= pc_inc_d;
            if (!freeze) begin
              pc_q    <= pc_inc_d;
              instr_q <= imem_rdata;
              valid_q <= 1'b1;
            end else begin
              // IF/ID is frozen; park the new word so it is not lost.
              hold_pc_q    <= pc_inc_d;
              hold_instr_q <= imem_rdata;
              state_q      <= HOLD;
            end
          end else if (!freeze) begin
            valid_q <= 1'b0;
          end
        end

        DROP: begin
          valid_q <= 1'b0;
          if (imem_ack) begin
            // A branch in the ack cycle is the newest target.
            fetch_pc_q <= branch_taken ? branch_addr : redirect_pc_q;
            state_q    <= FETCH;
          end else if (branch_taken) begin
            redirect_pc_q <= branch_addr;
          end
        end

        HOLD: begin
          if (branch_taken) begin
            valid_q    <= 1'b0;
            fetch_pc_q <= branch_addr;
            state_q    <= FETCH;
          end else if (!freeze) begin
            pc_q    <= hold_pc_q;
            instr_q <= hold_instr_q;
            valid_q <= 1'b1;
            state_q <= FETCH;
          end
        end

        default: state_q <= FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    fetch_busy = 1'b0;
    if (!rst) begin
      imem_req   = (state_q != HOLD);
      fetch_busy = (state_q == DROP) || ((state_q == FETCH) && !imem_ack);
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign pc_IF_ID    = pc_q;
  assign instr_IF_ID = instr_q;
  assign valid_IF_ID = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A default instance runs zero-wait, stall,
//   latency, redirect and reset scenarios; a second instance with
//   RESET_PC=0xFFFFFFFC covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_IF_ID;
  logic [31:0] instr_IF_ID;
  logic        valid_IF_ID;
  logic        fetch_busy;

  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic [31:0] rdata2;
  logic [31:0] pc2;
  logic [31:0] instr2;
  logic        valid2;
  logic        busy2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_IF_ID(pc_IF_ID), .instr_IF_ID(instr_IF_ID),
    .valid_IF_ID(valid_IF_ID), .fetch_busy(fetch_busy)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .freeze(1'b0),
    .branch_taken(1'b0), .branch_addr(32'h0),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2),
    .pc_IF_ID(pc2), .instr_IF_ID(instr2),
    .valid_IF_ID(valid2), .fetch_busy(busy2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check the request side, then clock.
  // exp_busy = x skips the busy check.
  task automatic fcycle(input string tag, input logic ack_v,
                        input logic [31:0] rd_v, input logic fr_v,
                        input logic br_v, input logic [31:0] ba_v,
                        input logic [31:0] exp_addr, input logic exp_req,
                        input logic exp_busy);
    imem_ack     = ack_v;
    imem_rdata   = rd_v;
    freeze       = fr_v;
    branch_taken = br_v;
    branch_addr  = ba_v;
    #1;
    check_eq({tag, ".req"}, {31'h0, imem_req}, {31'h0, exp_req});
    if (exp_req) check_eq({tag, ".addr"}, imem_addr, exp_addr);
    if (exp_busy !== 1'bx)
      check_eq({tag, ".busy"}, {31'h0, fetch_busy}, {31'h0, exp_busy});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc,
                          input logic [31:0] ins, input logic v);
    check_eq({tag, ".pc"}, pc_IF_ID, pc);
    check_eq({tag, ".instr"}, instr_IF_ID, ins);
    check_eq({tag, ".valid"}, {31'h0, valid_IF_ID}, {31'h0, v});
  endtask

  task automatic chk_v(input string tag, input logic v);
    check_eq({tag, ".valid"}, {31'h0, valid_IF_ID}, {31'h0, v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0; ack2 = 1'b0; rdata2 = '0;
    @(posedge clk); @(posedge clk); #1;

    // Reset state
    check_eq("rst.req", {31'h0, imem_req}, 32'h0);
    check_eq("rst.addr", imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    check_eq("rst.req2", {31'h0, req2}, 32'h0);
    check_eq("rst.addr2", addr2, 32'hFFFF_FFFC);

    // Zero-wait memory, no stalls; wrap instance runs alongside
    rst = 1'b0;
    ack2 = 1'b1; rdata2 = 32'hB000_0000;
    #1 check_eq("wrap.addr0", addr2, 32'hFFFF_FFFC);
    fcycle("zw0", 1'b1, 32'h1000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk_ifid("zw0", 32'h4, 32'h1000_0000, 1'b1);
    check_eq("wrap.pc0", pc2, 32'h0);
    check_eq("wrap.instr0", instr2, 32'hB000_0000);
    check_eq("wrap.valid0", {31'h0, valid2}, 32'h1);
    check_eq("wrap.addr1", addr2, 32'h0);
    rdata2 = 32'hB000_0001;
    fcycle("zw1", 1'b1, 32'h1000_0004, 1'b0, 1'b0, 32'h0, 32'h4, 1'b1, 1'b0);
    chk_ifid("zw1", 32'h8, 32'h1000_0004, 1'b1);
    check_eq("wrap.pc1", pc2, 32'h4);
    check_eq("wrap.instr1", instr2, 32'hB000_0001);
    ack2 = 1'b0;
    fcycle("zw2", 1'b1, 32'h1000_0008, 1'b0, 1'b0, 32'h0, 32'h8, 1'b1, 1'b0);
    chk_ifid("zw2", 32'hC, 32'h1000_0008, 1'b1);
    fcycle("zw3", 1'b1, 32'h1000_000C, 1'b0, 1'b0, 32'h0, 32'hC, 1'b1, 1'b0);
    chk_ifid("zw3", 32'h10, 32'h1000_000C, 1'b1);

    // Freeze for 3 cycles, ack arrives while frozen at 0x10
    fcycle("fz0", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h10, 1'b1, 1'b1);
    chk_ifid("fz0", 32'h10, 32'h1000_000C, 1'b1);
    fcycle("fz1", 1'b1, 32'hAAAA_0000, 1'b1, 1'b0, 32'h0, 32'h10, 1'b1, 1'b0);
    chk_ifid("fz1", 32'h10, 32'h1000_000C, 1'b1);
    fcycle("fz2", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h14, 1'b0, 1'b0);
    chk_ifid("fz2", 32'h10, 32'h1000_000C, 1'b1);
    fcycle("fz3", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h14, 1'b0, 1'b0);
    chk_ifid("fz3", 32'h14, 32'hAAAA_0000, 1'b1);

    // Two-cycle memory latency at 0x14 and 0x18
    fcycle("lat0", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h14, 1'b1, 1'b1);
    chk_v("lat0", 1'b0);
    fcycle("lat1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h14, 1'b1, 1'b1);
    chk_v("lat1", 1'b0);
    fcycle("lat2", 1'b1, 32'h2000_0014, 1'b0, 1'b0, 32'h0, 32'h14, 1'b1, 1'b0);
    chk_ifid("lat2", 32'h18, 32'h2000_0014, 1'b1);
    fcycle("lat3", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h18, 1'b1, 1'b1);
    chk_v("lat3", 1'b0);
    fcycle("lat4", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h18, 1'b1, 1'b1);
    chk_v("lat4", 1'b0);
    fcycle("lat5", 1'b1, 32'h2000_0018, 1'b0, 1'b0, 32'h0, 32'h18, 1'b1, 1'b0);
    chk_ifid("lat5", 32'h1C, 32'h2000_0018, 1'b1);
    fcycle("lat6", 1'b1, 32'h2000_001C, 1'b0, 1'b0, 32'h0, 32'h1C, 1'b1, 1'b0);
    chk_ifid("lat6", 32'h20, 32'h2000_001C, 1'b1);

    // Branch to 0x100 during a wait at 0x20
    fcycle("br0", 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h20, 1'b1, 1'b1);
    chk_v("br0", 1'b0);
    fcycle("br1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h20, 1'b1, 1'b1);
    chk_v("br1", 1'b0);
    fcycle("br2", 1'b1, 32'hDEAD_0020, 1'b0, 1'b0, 32'h0, 32'h20, 1'b1, 1'b1);
    chk_v("br2", 1'b0);
    fcycle("br3", 1'b1, 32'h3000_0100, 1'b0, 1'b0, 32'h0, 32'h100, 1'b1, 1'b0);
    chk_ifid("br3", 32'h104, 32'h3000_0100, 1'b1);

    // Branch with freeze while in HOLD discards the hold buffer
    fcycle("hb0", 1'b1, 32'h4000_0104, 1'b1, 1'b0, 32'h0, 32'h104, 1'b1, 1'b0);
    chk_ifid("hb0", 32'h104, 32'h3000_0100, 1'b1);
    fcycle("hb1", 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h108, 1'b0, 1'b0);
    chk_v("hb1", 1'b0);
    fcycle("hb2", 1'b1, 32'h5000_0200, 1'b0, 1'b0, 32'h0, 32'h200, 1'b1, 1'b0);
    chk_ifid("hb2", 32'h204, 32'h5000_0200, 1'b1);

    // Branch coinciding with ack in FETCH: data dropped, refetch at target
    fcycle("ba0", 1'b1, 32'hDEAD_0204, 1'b0, 1'b1, 32'h300, 32'h204, 1'b1, 1'b0);
    chk_v("ba0", 1'b0);
    fcycle("ba1", 1'b1, 32'h6000_0300, 1'b0, 1'b0, 32'h0, 32'h300, 1'b1, 1'b0);
    chk_ifid("ba1", 32'h304, 32'h6000_0300, 1'b1);

    // Reset mid-transaction; ack in the reset cycle is ignored
    fcycle("mr0", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h304, 1'b1, 1'b1);
    rst = 1'b1;
    fcycle("mr1", 1'b1, 32'h7000_0304, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'bx);
    chk_ifid("mr1", 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    fcycle("mr2", 1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk_ifid("mr2", 32'h4, 32'h8000_0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
